uart_transmitter: RTL and testbench

Serialises bytes onto an asynchronous UART line: idle-high, one start bit, LSB-first data, configurable stop bits. Sits directly upstream of `uart_receiver` on the board link and in loopback benches; its `serial_out` drives the receiver's `signal_in`. Accepts bytes over a valid/ready handshake and supports back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_symbol_timer.sv | 39 +++
 rtl/uart_transmitter.sv | 142 ++++++++++++++
 tb/tb_uart_transmitter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmitter and receiver: the frame-state
// enum, default bit-rate constants and a counter-width helper.
// No ports (package).
package uart_pkg;

  // Frame states, shared by the transmitter and receiver FSMs.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Board clock and line rate.
  localparam int unsigned CLK_FREQ_HZ = 125_000_000;
  localparam int unsigned BAUD_115200 = 115_200;
  localparam int unsigned CYCLES_PER_SYMBOL_115200 = CLK_FREQ_HZ / BAUD_115200;

  // Short symbol periods that keep simulation runs small.
  localparam int unsigned BENCH_CYCLES_PER_SYMBOL_1 = 1;
  localparam int unsigned BENCH_CYCLES_PER_SYMBOL_3 = 3;
  localparam int unsigned BENCH_CYCLES_PER_SYMBOL_4 = 4;

  // Width of a counter that runs 0..max_value. A counter whose maximum is 0
  // still gets one bit so that no zero-width vectors appear.
  function automatic int unsigned count_width(input int unsigned max_value);
    if (max_value < 1) begin
      return 1;
    end
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/uart_symbol_timer.sv
// uart_symbol_timer
// Free-running symbol-period counter 0..CYCLES_PER_SYMBOL-1. It wraps on its
// own at the end of each symbol and returns to 0 when restart is sampled high.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset (count -> 0)
//   restart  in  force count to 0 on the next edge
//   last     out high in the final cycle of the current symbol
module uart_symbol_timer
  import uart_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SYMBOL = CYCLES_PER_SYMBOL_115200
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic last
);

  localparam int unsigned CW = count_width(CYCLES_PER_SYMBOL - 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CYCLES_PER_SYMBOL - 1);

  logic [CW-1:0] count;

  // With CYCLES_PER_SYMBOL = 1 the count never leaves 0, so every cycle is
  // the last one of its symbol.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      count <= '0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == LAST_COUNT);

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter
// Serialises bytes onto an idle-high UART line: one start bit, DATA_BITS data
// bits LSB first, STOP_BITS stop bits. Frames run back to back when a new byte
// is offered during the final stop cycle.
// Ports:
//   clk            in  clock, rising edge
//   rst            in  synchronous active-high reset
//   data_in[7:0]   in  byte to send; bits above DATA_BITS-1 are ignored
//   data_in_valid  in  source has a byte
//   data_in_ready  out transmitter accepts a byte this cycle
//   serial_out     out registered UART line, idle high
//
// Handshake: a byte transfers on a rising edge where data_in_valid and
// data_in_ready are both high. data_in_ready depends only on the FSM state
// and rst (never on data_in_valid); it is high in IDLE and in the final cycle
// of the final stop bit, and low whenever rst is high. data_in is captured at
// the transfer edge, so the source may change it freely afterwards.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SYMBOL = CYCLES_PER_SYMBOL_115200,
  parameter int unsigned DATA_BITS         = 8,
  parameter int unsigned STOP_BITS         = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int unsigned BW = count_width(DATA_BITS - 1);
  localparam int unsigned SW = count_width(STOP_BITS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);

  uart_state_t          state;
  uart_state_t          state_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [BW-1:0]        bit_idx;
  logic [BW-1:0]        bit_idx_next;
  logic [SW-1:0]        stop_cnt;
  logic [SW-1:0]        stop_cnt_next;
  logic                 line_next;
  logic                 transfer;
  logic                 symbol_last;
  logic                 timer_restart;

  uart_symbol_timer #(
    .CYCLES_PER_SYMBOL(CYCLES_PER_SYMBOL)
  ) u_symbol_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(timer_restart),
    .last   (symbol_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      stop_cnt   <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_idx    <= bit_idx_next;
      stop_cnt   <= stop_cnt_next;
      serial_out <= line_next;
    end
  end

  // line_next is the level that belongs to the current state; registering
  // it delays the whole waveform by exactly one cycle, so the start bit
  // appears one edge after the accepting edge and frame length is unchanged.
  always_comb begin
    state_next    = state;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx;
    stop_cnt_next = stop_cnt;
    data_in_ready = 1'b0;
    line_next     = 1'b1;

    unique case (state)
      IDLE: begin
        data_in_ready = 1'b1;
      end
      START: begin
        line_next = 1'b0;
        if (symbol_last) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        line_next = shift_reg[0];
        if (symbol_last) begin
          shift_next = shift_reg >> 1;
          if (bit_idx == LAST_BIT) begin
            state_next    = STOP;
            stop_cnt_next = '0;
          end else begin
            bit_idx_next = bit_idx + BW'(1);
          end
        end
      end
      STOP: begin
        if (symbol_last) begin
          if (stop_cnt == LAST_STOP) begin
            data_in_ready = 1'b1;
            state_next    = IDLE;
          end else begin
            stop_cnt_next = stop_cnt + SW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (rst) begin
      data_in_ready = 1'b0;
    end

    // A transfer overrides the IDLE/STOP decision and starts a new frame,
    // which is what makes back-to-back frames gapless.
    transfer = data_in_valid && data_in_ready;
    if (transfer) begin
      state_next = START;
      shift_next = data_in[DATA_BITS-1:0];
    end

    // The timer is held at 0 while idle and restarted on every state entry,
    // including STOP -> START.
    timer_restart = (state == IDLE) || (state_next != state);
  end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

  localparam int DB      = 8;
  localparam int CPS_A   = 4;
  localparam int SB_A    = 1;
  localparam int CPS_B   = 3;
  localparam int SB_B    = 2;
  localparam int CPS_C   = 1;
  localparam int SB_C    = 1;
  localparam int FRAME_A = (1 + DB + SB_A) * CPS_A;
  localparam int FRAME_B = (1 + DB + SB_B) * CPS_B;
  localparam int FRAME_C = (1 + DB + SB_C) * CPS_C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [7:0] data_a, data_b, data_c;
  logic       valid_a, valid_b, valid_c;
  logic       ready_a, ready_b, ready_c;
  logic       line_a, line_b, line_c;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_transmitter #(.CYCLES_PER_SYMBOL(CPS_A), .DATA_BITS(DB), .STOP_BITS(SB_A)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_a), .data_in_valid(valid_a),
    .data_in_ready(ready_a), .serial_out(line_a));

  uart_transmitter #(.CYCLES_PER_SYMBOL(CPS_B), .DATA_BITS(DB), .STOP_BITS(SB_B)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_b), .data_in_valid(valid_b),
    .data_in_ready(ready_b), .serial_out(line_b));

  uart_transmitter #(.CYCLES_PER_SYMBOL(CPS_C), .DATA_BITS(DB), .STOP_BITS(SB_C)) dut_c (
    .clk(clk), .rst(rst), .data_in(data_c), .data_in_valid(valid_c),
    .data_in_ready(ready_c), .serial_out(line_c));

  // ---------------- reference model ----------------
  // Line level of symbol s in a frame carrying b: start, data LSB first, stops.
  function automatic logic frame_level(input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s <= DB) return b[s-1];
    return 1'b1;
  endfunction

  // ---------------- behavioural receiver on dut_c (one bit per cycle) ----------------
  int         cyc = 0;
  bit         mon_busy = 0;
  int         mon_bit = 0;
  logic [7:0] mon_byte = '0;
  logic [7:0] mon_exp;
  int         last_start = -1;
  int         rx_count = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon_busy   = 0;
      last_start = -1;
    end else if (!mon_busy) begin
      if (line_c === 1'b0) begin
        mon_busy = 1;
        mon_bit  = 0;
        if (last_start >= 0) begin
          checks++;
          if (cyc - last_start != FRAME_C) begin
            errors++;
            $display("FAIL b2b_start_spacing got %0d expected %0d", cyc - last_start, FRAME_C);
          end
        end
        last_start = cyc;
      end
    end else if (mon_bit < DB) begin
      mon_byte[mon_bit] = line_c;
      mon_bit++;
    end else begin
      mon_busy = 0;
      rx_count++;
      checks++;
      if (line_c !== 1'b1) begin
        errors++;
        $display("FAIL b2b_stop_bit got %b expected 1", line_c);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_unexpected_byte got %02h expected none", mon_byte);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_byte !== mon_exp) begin
          errors++;
          $display("FAIL b2b_byte got %02h expected %02h", mon_byte, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers b to dut_a, returns 1 time unit after the accepting edge.
  task automatic accept_a(input logic [7:0] b);
    int guard = 0;
    data_a  = b;
    valid_a = 1'b1;
    while (ready_a !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    checks++;
    if (ready_a !== 1'b1) begin
      errors++;
      $display("FAIL accept_a_timeout got ready=%b expected 1", ready_a);
    end
    step();
    valid_a = 1'b0;
  endtask

  // Checks one full dut_a frame starting right after its accepting edge.
  task automatic check_frame_a(input logic [7:0] b, input bit scramble);
    for (int k = 0; k < FRAME_A; k++) begin
      checks++;
      if (ready_a !== (k == FRAME_A - 1)) begin
        errors++;
        $display("FAIL frame_a_ready byte %02h cycle %0d got %b expected %b",
                 b, k, ready_a, (k == FRAME_A - 1));
      end
      if (scramble) data_a = 8'($urandom);
      step();
      checks++;
      if (line_a !== frame_level(b, k / CPS_A)) begin
        errors++;
        $display("FAIL frame_a_line byte %02h cycle %0d got %b expected %b",
                 b, k, line_a, frame_level(b, k / CPS_A));
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;
    repeat (3) begin
      step();
      checks += 2;
      if (line_a !== 1'b1) begin
        errors++;
        $display("FAIL reset_line got %b expected 1", line_a);
      end
      if (ready_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready got %b expected 0", ready_a);
      end
    end
    rst = 1'b0;
    #1;
    checks += 3;
    if (ready_a !== 1'b1) begin errors++; $display("FAIL post_reset_ready_a got %b expected 1", ready_a); end
    if (ready_b !== 1'b1) begin errors++; $display("FAIL post_reset_ready_b got %b expected 1", ready_b); end
    if (ready_c !== 1'b1) begin errors++; $display("FAIL post_reset_ready_c got %b expected 1", ready_c); end
    for (int i = 0; i < 100; i++) begin
      step();
      checks += 2;
      if (line_a !== 1'b1) begin errors++; $display("FAIL idle_line cycle %0d got %b expected 1", i, line_a); end
      if (ready_a !== 1'b1) begin errors++; $display("FAIL idle_ready cycle %0d got %b expected 1", i, ready_a); end
    end
  endtask

  task automatic test_frame_a5();
    accept_a(8'hA5);
    check_frame_a(8'hA5, 1'b0);
  endtask

  task automatic test_data_hold();
    accept_a(8'h5A);
    check_frame_a(8'h5A, 1'b1);
  endtask

  task automatic test_random_frames();
    logic [7:0] b;
    int gap;
    repeat (6) begin
      b   = 8'($urandom);
      gap = $urandom_range(0, 5);
      for (int i = 0; i < gap; i++) begin
        step();
        checks++;
        if (line_a !== 1'b1) begin errors++; $display("FAIL random_gap_line got %b expected 1", line_a); end
      end
      accept_a(b);
      check_frame_a(b, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_frame();
    accept_a(8'h3C);
    // Symbol 4 (data bit 3) occupies samples k = 16..19.
    for (int k = 0; k < 18; k++) begin
      step();
      checks++;
      if (line_a !== frame_level(8'h3C, k / CPS_A)) begin
        errors++;
        $display("FAIL pre_reset_line cycle %0d got %b expected %b", k, line_a, frame_level(8'h3C, k / CPS_A));
      end
    end
    rst     = 1'b1;
    valid_a = 1'b1;
    data_a  = 8'h00;
    #1;
    checks++;
    if (ready_a !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b expected 0", ready_a); end
    step();
    checks += 2;
    if (line_a !== 1'b1) begin errors++; $display("FAIL mid_reset_line got %b expected 1", line_a); end
    if (ready_a !== 1'b0) begin errors++; $display("FAIL mid_reset_ready_hold got %b expected 0", ready_a); end
    rst     = 1'b0;
    valid_a = 1'b0;
    #1;
    // Neither the abandoned frame nor the byte offered during reset may appear.
    for (int i = 0; i < 12; i++) begin
      checks += 2;
      if (ready_a !== 1'b1) begin errors++; $display("FAIL after_reset_ready cycle %0d got %b expected 1", i, ready_a); end
      step();
      if (line_a !== 1'b1) begin errors++; $display("FAIL after_reset_line cycle %0d got %b expected 1", i, line_a); end
    end
    accept_a(8'h81);
    check_frame_a(8'h81, 1'b0);
  endtask

  task automatic test_two_stop();
    int guard = 0;
    logic exp_line;
    data_b  = 8'h00;
    valid_b = 1'b1;
    while (ready_b !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    checks++;
    if (ready_b !== 1'b1) begin errors++; $display("FAIL two_stop_accept got %b expected 1", ready_b); end
    step();
    data_b = 8'hFF;
    for (int k = 0; k < 2 * FRAME_B; k++) begin
      if (k == FRAME_B) valid_b = 1'b0;
      checks++;
      if (ready_b !== ((k == FRAME_B - 1) || (k == 2 * FRAME_B - 1))) begin
        errors++;
        $display("FAIL two_stop_ready cycle %0d got %b", k, ready_b);
      end
      exp_line = (k < FRAME_B) ? frame_level(8'h00, k / CPS_B) : frame_level(8'hFF, (k - FRAME_B) / CPS_B);
      step();
      checks++;
      if (line_b !== exp_line) begin
        errors++;
        $display("FAIL two_stop_line cycle %0d got %b expected %b", k, line_b, exp_line);
      end
    end
    repeat (5) begin
      step();
      checks++;
      if (line_b !== 1'b1) begin errors++; $display("FAIL two_stop_idle got %b expected 1", line_b); end
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    int sent = 0;
    logic [7:0] cur = 8'h00;
    logic rdy;
    data_c  = cur;
    valid_c = 1'b1;
    while (sent < 256 && guard < 256 * FRAME_C + 100) begin
      rdy = ready_c;
      @(posedge clk);
      if (rdy === 1'b1) begin
        exp_q.push_back(cur);
        sent++;
        cur++;
      end
      #1;
      data_c = cur;
      guard++;
    end
    valid_c = 1'b0;
    checks++;
    if (sent != 256) begin errors++; $display("FAIL b2b_sent got %0d expected 256", sent); end
    repeat (3 * FRAME_C) step();
    checks += 2;
    if (rx_count != 256) begin errors++; $display("FAIL b2b_rx_count got %0d expected 256", rx_count); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d expected 0", exp_q.size()); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst = 1'b1;
    test_reset();
    test_frame_a5();
    test_data_hold();
    test_random_frames();
    test_reset_mid_frame();
    test_two_stop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
